// File: rtl/ws2812b_pkg.sv
// Shared types and constants for the WS2812B frame buffer: channel widths, colour field offsets,
// FSM encoding and the colour reorder/brightness helpers.
package ws2812b_pkg;

  localparam int unsigned CH_W  = 8;
  localparam int unsigned PIX_W = 3 * CH_W;

  // Stored host word is {R, G, B}
  localparam int unsigned IN_R_OFS = 16;
  localparam int unsigned IN_G_OFS = 8;
  localparam int unsigned IN_B_OFS = 0;

  // Word presented to the serializer is {G, R, B}
  localparam int unsigned OUT_G_OFS = 16;
  localparam int unsigned OUT_R_OFS = 8;
  localparam int unsigned OUT_B_OFS = 0;

  // 50 us of idle line at 100 MHz
  localparam int unsigned LATCH_CYCLES_DEFAULT = 5000;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_SEND  = 2'd2,
    ST_LATCH = 2'd3
  } state_t;

  function automatic logic [PIX_W-1:0] rgb_to_grb(input logic [PIX_W-1:0] c);
    logic [PIX_W-1:0] o;
    o = '0;
    o[OUT_G_OFS +: CH_W] = c[IN_G_OFS +: CH_W];
    o[OUT_R_OFS +: CH_W] = c[IN_R_OFS +: CH_W];
    o[OUT_B_OFS +: CH_W] = c[IN_B_OFS +: CH_W];
    return o;
  endfunction

  // (c * (b + 1)) >> 8: 255 is identity, 0 blanks the channel
  function automatic logic [CH_W-1:0] scale_ch(input logic [CH_W-1:0] c, input logic [CH_W-1:0] b);
    logic [2*CH_W-1:0] p;
    p = (2*CH_W)'(c) * ((2*CH_W)'(b) + (2*CH_W)'(1));
    return p[2*CH_W-1:CH_W];
  endfunction

  function automatic logic [PIX_W-1:0] scale_pix(input logic [PIX_W-1:0] c, input logic [CH_W-1:0] b);
    logic [PIX_W-1:0] o;
    for (int i = 0; i < 3; i++) o[i*CH_W +: CH_W] = scale_ch(c[i*CH_W +: CH_W], b);
    return o;
  endfunction

endpackage

// File: rtl/ws2812b_pixel_ram.sv
// Simple dual-port pixel store: synchronous read-first read port, write port that drops
// addresses at or beyond DEPTH.
module ws2812b_pixel_ram
  import ws2812b_pkg::*;
#(
  parameter int unsigned DEPTH  = 3,
  parameter int unsigned ADDR_W = 2
) (
  input  logic              clk_i,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] waddr_i,
  input  logic [PIX_W-1:0]  wdata_i,
  input  logic              re_i,
  input  logic [ADDR_W-1:0] raddr_i,
  output logic [PIX_W-1:0]  rdata_o
);

  localparam int unsigned SLOTS = 2 ** ADDR_W;
  localparam int unsigned CMP_W = ADDR_W + 1;

  logic [PIX_W-1:0] mem [SLOTS];
  logic             we_ok;

  assign we_ok = we_i && ({1'b0, waddr_i} < CMP_W'(DEPTH));

  // Non-blocking update gives old data on a same-address read/write
  always_ff @(posedge clk_i) begin
    if (re_i)  rdata_o        <= mem[raddr_i];
    if (we_ok) mem[waddr_i]   <= wdata_i;
  end

endmodule

// File: rtl/ws2812b_frame_buffer.sv
// Frame store and sequencer feeding the WS2812B serializer. Define WS2812B_BRIGHTNESS_EN to add
// the brightness_i port and per-channel scaling of the streamed colour.
module ws2812b_frame_buffer
  import ws2812b_pkg::*;
#(
  parameter  int unsigned N_LEDS       = 3,
  parameter  int unsigned LATCH_CYCLES = LATCH_CYCLES_DEFAULT,
  localparam int unsigned ADDR_W       = (N_LEDS > 1) ? $clog2(N_LEDS) : 1
) (
  input  logic              clk_i,
  input  logic              rst_i,
`ifdef WS2812B_BRIGHTNESS_EN
  input  logic [CH_W-1:0]   brightness_i,
`endif
  input  logic              wr_en_i,
  input  logic [ADDR_W-1:0] wr_addr_i,
  input  logic [PIX_W-1:0]  wr_data_i,
  input  logic              start_i,
  output logic              pix_valid_o,
  input  logic              pix_ready_i,
  output logic [PIX_W-1:0]  pix_data_o,
  output logic              pix_last_o,
  input  logic              ser_busy_i,
  output logic              busy_o,
  output logic              frame_done_o
);

  localparam int unsigned CNT_W = (LATCH_CYCLES > 1) ? $clog2(LATCH_CYCLES + 1) : 1;
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(N_LEDS - 1);
  localparam logic [CNT_W-1:0]  LAST_CNT  = CNT_W'(LATCH_CYCLES - 1);

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              ram_re;
  logic [PIX_W-1:0]  ram_rdata;
  logic [PIX_W-1:0]  colour;
  logic              pix_valid_d, pix_last_d, busy_d, done_d;
  logic [PIX_W-1:0]  pix_data_d;

  ws2812b_pixel_ram #(
    .DEPTH  (N_LEDS),
    .ADDR_W (ADDR_W)
  ) u_ram (
    .clk_i   (clk_i),
    .we_i    (wr_en_i),
    .waddr_i (wr_addr_i),
    .wdata_i (wr_data_i),
    .re_i    (ram_re),
    .raddr_i (rd_addr_d),
    .rdata_o (ram_rdata)
  );

  // RAM is read on entry to FETCH; the colour is reordered/scaled into the output register
`ifdef WS2812B_BRIGHTNESS_EN
  assign colour = scale_pix(rgb_to_grb(ram_rdata), brightness_i);
`else
  assign colour = rgb_to_grb(ram_rdata);
`endif

  always_comb begin
    state_d     = state_q;
    rd_addr_d   = rd_addr_q;
    cnt_d       = cnt_q;
    ram_re      = 1'b0;
    pix_valid_d = 1'b0;
    pix_last_d  = pix_last_o;
    pix_data_d  = pix_data_o;
    done_d      = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start_i) begin
          state_d   = ST_FETCH;
          rd_addr_d = '0;
          ram_re    = 1'b1;
        end
      end
      ST_FETCH: begin
        state_d     = ST_SEND;
        pix_valid_d = 1'b1;
        pix_last_d  = (rd_addr_q == LAST_ADDR);
        pix_data_d  = colour;
      end
      ST_SEND: begin
        pix_valid_d = 1'b1;
        if (pix_ready_i) begin
          pix_valid_d = 1'b0;
          pix_last_d  = 1'b0;
          if (rd_addr_q == LAST_ADDR) begin
            state_d = ST_LATCH;
            cnt_d   = '0;
          end else begin
            state_d   = ST_FETCH;
            rd_addr_d = rd_addr_q + ADDR_W'(1);
            ram_re    = 1'b1;
          end
        end
      end
      ST_LATCH: begin
        // The gap only counts once the serializer has finished shifting
        if (ser_busy_i) begin
          cnt_d = '0;
        end else if (cnt_q == LAST_CNT) begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q      <= ST_IDLE;
      rd_addr_q    <= '0;
      cnt_q        <= '0;
      pix_valid_o  <= 1'b0;
      pix_last_o   <= 1'b0;
      pix_data_o   <= '0;
      busy_o       <= 1'b0;
      frame_done_o <= 1'b0;
    end else begin
      state_q      <= state_d;
      rd_addr_q    <= rd_addr_d;
      cnt_q        <= cnt_d;
      pix_valid_o  <= pix_valid_d;
      pix_last_o   <= pix_last_d;
      pix_data_o   <= pix_data_d;
      busy_o       <= busy_d;
      frame_done_o <= done_d;
    end
  end

endmodule

// File: tb/tb_ws2812b_frame_buffer.sv
// Scoreboard bench for ws2812b_frame_buffer (3 LEDs, 20-cycle latch gap); exercises the
// brightness path too when WS2812B_BRIGHTNESS_EN is defined.
module tb_ws2812b_frame_buffer;

  localparam int unsigned N_LEDS = 3;
  localparam int unsigned LATCH  = 20;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic        wr_en_i = 1'b0;
  logic [1:0]  wr_addr_i = '0;
  logic [23:0] wr_data_i = '0;
  logic        start_i = 1'b0;
  logic        pix_ready_i = 1'b0;
  logic        ser_busy_i = 1'b0;
  logic        pix_valid_o, pix_last_o, busy_o, frame_done_o;
  logic [23:0] pix_data_o;
`ifdef WS2812B_BRIGHTNESS_EN
  logic [7:0]  brightness_i = 8'hFF;
`endif

  int checks = 0;
  int failures = 0;
  logic [24:0] exp_q[$];
  logic [24:0] mon_e;

  ws2812b_frame_buffer #(.N_LEDS(N_LEDS), .LATCH_CYCLES(LATCH)) dut (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
`ifdef WS2812B_BRIGHTNESS_EN
    .brightness_i (brightness_i),
`endif
    .wr_en_i      (wr_en_i),
    .wr_addr_i    (wr_addr_i),
    .wr_data_i    (wr_data_i),
    .start_i      (start_i),
    .pix_valid_o  (pix_valid_o),
    .pix_ready_i  (pix_ready_i),
    .pix_data_o   (pix_data_o),
    .pix_last_o   (pix_last_o),
    .ser_busy_i   (ser_busy_i),
    .busy_o       (busy_o),
    .frame_done_o (frame_done_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: every accepted pixel is compared against the oldest expected entry
  always @(negedge clk_i) begin
    if (!rst_i && pix_valid_o && pix_ready_i) begin
      if (exp_q.size() == 0) begin
        check("unexpected_pixel", 32'd1, 32'd0);
      end else begin
        mon_e = exp_q.pop_front();
        check("pix_data", {8'h0, pix_data_o}, {8'h0, mon_e[23:0]});
        check("pix_last", {31'h0, pix_last_o}, {31'h0, mon_e[24]});
      end
    end
  end

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic wr(input logic [1:0] a, input logic [23:0] d);
    wr_en_i = 1'b1; wr_addr_i = a; wr_data_i = d;
    tick();
    wr_en_i = 1'b0;
  endtask

  task automatic start_frame(input logic [23:0] e0, input logic [23:0] e1, input logic [23:0] e2);
    exp_q.push_back({1'b0, e0});
    exp_q.push_back({1'b0, e1});
    exp_q.push_back({1'b1, e2});
    start_i = 1'b1;
    tick();
    start_i = 1'b0;
  endtask

  task automatic wait_done();
    int n = 0;
    while (!frame_done_o && n < 500) begin tick(); n++; end
    check("frame_done_seen", {31'h0, frame_done_o}, 32'd1);
  endtask

  task automatic wait_last();
    int n = 0;
    while (!(pix_valid_o && pix_last_o) && n < 200) begin tick(); n++; end
    check("last_pixel_seen", {31'h0, pix_valid_o && pix_last_o}, 32'd1);
  endtask

  task automatic wait_valid();
    int n = 0;
    while (!pix_valid_o && n < 50) begin tick(); n++; end
    check("valid_seen", {31'h0, pix_valid_o}, 32'd1);
  endtask

  initial begin
    int n;
    int stable;
    logic [23:0] d0;

    tick(); tick();
    check("rst_valid", {31'h0, pix_valid_o}, 32'd0);
    check("rst_data", {8'h0, pix_data_o}, 32'd0);
    check("rst_last", {31'h0, pix_last_o}, 32'd0);
    check("rst_busy", {31'h0, busy_o}, 32'd0);
    check("rst_done", {31'h0, frame_done_o}, 32'd0);
    rst_i = 1'b0;
    tick();

    // Frame 1: basic GRB reorder, latency, latch gap measured from ser_busy falling
    wr(2'd0, 24'hFF0000);
    wr(2'd1, 24'h00FF00);
    wr(2'd2, 24'h0000FF);
    pix_ready_i = 1'b1;
    ser_busy_i  = 1'b1;
    start_frame(24'h00FF00, 24'hFF0000, 24'h0000FF);
    check("f1_busy", {31'h0, busy_o}, 32'd1);
    check("f1_fetch_valid", {31'h0, pix_valid_o}, 32'd0);
    tick();
    check("f1_latency", {31'h0, pix_valid_o}, 32'd1);
    wait_last();
    tick();
    for (int i = 0; i < 5; i++) tick();
    check("f1_held_by_ser_busy", {31'h0, busy_o}, 32'd1);
    ser_busy_i = 1'b0;
    n = 0;
    do begin tick(); n++; end while (!frame_done_o && n < 200);
    check("f1_latch_gap", n, LATCH);
    check("f1_busy_done", {31'h0, busy_o}, 32'd0);

    // Frame 2: start on the done cycle, stall 10 cycles, ignored starts mid-frame
    pix_ready_i = 1'b0;
    start_frame(24'h00FF00, 24'hFF0000, 24'h0000FF);
    check("f2_fetch_valid", {31'h0, pix_valid_o}, 32'd0);
    start_i = 1'b1;
    tick();
    check("f2_latency", {31'h0, pix_valid_o}, 32'd1);
    d0 = pix_data_o;
    stable = 0;
    for (int i = 0; i < 10; i++) begin
      if (pix_valid_o && pix_data_o == d0 && !pix_last_o) stable++;
      tick();
      start_i = 1'b0;
    end
    check("f2_hold_stable", stable, 10);
    pix_ready_i = 1'b1;
    tick();
    pix_ready_i = 1'b0;
    check("f2_gap", {31'h0, pix_valid_o}, 32'd0);
    tick();
    check("f2_next_latency", {31'h0, pix_valid_o}, 32'd1);
    pix_ready_i = 1'b1;
    wait_last();
    tick();
    start_i = 1'b1;
    tick();
    start_i = 1'b0;
    wait_done();
    tick(); tick(); tick();
    check("f2_no_second_busy", {31'h0, busy_o}, 32'd0);
    check("f2_no_second_valid", {31'h0, pix_valid_o}, 32'd0);

    // Frame 3: out-of-range write dropped; write during LED1 fetch streams old value
    wr(2'd3, 24'hABCDEF);
    start_frame(24'h00FF00, 24'hFF0000, 24'h0000FF);
    tick();
    tick();
    wr(2'd1, 24'h123456);
    wait_done();
    tick();

    // Frame 4: new LED1 colour visible
    start_frame(24'h00FF00, 24'h341256, 24'h0000FF);
    wait_done();
    tick();

    // Frame 5: reset while the second pixel is pending
    pix_ready_i = 1'b0;
    start_frame(24'h00FF00, 24'h341256, 24'h0000FF);
    wait_valid();
    pix_ready_i = 1'b1;
    tick();
    pix_ready_i = 1'b0;
    tick();
    wait_valid();
    #2 rst_i = 1'b1;
    #1;
    check("rst_mid_valid", {31'h0, pix_valid_o}, 32'd0);
    check("rst_mid_data", {8'h0, pix_data_o}, 32'd0);
    check("rst_mid_last", {31'h0, pix_last_o}, 32'd0);
    check("rst_mid_busy", {31'h0, busy_o}, 32'd0);
    check("rst_flush", exp_q.size(), 2);
    while (exp_q.size() > 0) void'(exp_q.pop_front());
    tick(); tick();
    rst_i = 1'b0;
    tick();

    // Frame 6: RAM retained across reset
    pix_ready_i = 1'b1;
    start_frame(24'h00FF00, 24'h341256, 24'h0000FF);
    wait_done();
    tick();

`ifdef WS2812B_BRIGHTNESS_EN
    wr(2'd0, 24'hFF8040);
    brightness_i = 8'h7F;
    start_frame(24'h407F20, 24'h1A092B, 24'h00007F);
    wait_done();
    tick();
    brightness_i = 8'hFF;
    start_frame(24'h80FF40, 24'h341256, 24'h0000FF);
    wait_done();
    tick();
    brightness_i = 8'h00;
    start_frame(24'h000000, 24'h000000, 24'h000000);
    wait_done();
    tick();
`endif

    tick(); tick();
    check("scoreboard_drain", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
